// File: rtl/cordic_exp_scheduler_pkg.sv
// Shared constants, state encoding and operand helper for the exp-engine scheduler.
package cordic_exp_pkg;
  localparam int Z_W     = 7;
  localparam int XY_W    = 8;
  localparam int MAX_REQ = 8;
  localparam logic signed [XY_W-1:0] X_INIT = 8'sd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Operand idx out of a packed vector sized for the largest requester count.
  function automatic logic signed [Z_W-1:0] z_slice(input logic [MAX_REQ*Z_W-1:0] packed_z,
                                                    input int idx);
    return Z_W'(packed_z >> (idx * Z_W));
  endfunction
endpackage

// File: rtl/cordic_exp_scheduler_if.sv
// Request/response channel between the neuron array and the exp scheduler.
interface cordic_exp_scheduler_if #(
  parameter int N_REQ = 4
);
  import cordic_exp_pkg::*;
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*Z_W-1:0]   req_z;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic signed [XY_W-1:0] rsp_exp;
  logic                   rsp_timeout;

  modport slave (
    input  req_valid, req_z, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_exp, rsp_timeout
  );

  modport master (
    output req_valid, req_z, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_exp, rsp_timeout
  );
endinterface

// File: rtl/cordic_exp_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a pointer that
// advances past the winner only when a grant is actually issued.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     en,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   slot;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    slot      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      slot = {1'b0, ptr} + (IDX_W+1)'(i);
      if (slot >= (IDX_W+1)'(N_REQ)) slot = slot - (IDX_W+1)'(N_REQ);
      if (!found && req[slot[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = slot[IDX_W-1:0];
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/cordic_exp_scheduler.sv
// Shares one pipelined hyperbolic CORDIC exp engine between N_REQ requesters.
//  state | meaning
//  IDLE  | engine parked in init, arbitrating requests
//  INIT  | operand loaded, eng_init held for INIT_CYCLES
//  RUN   | engine released, waiting for confirmed done or timeout
//  HOLD  | result presented on rsp_*, waiting for rsp_ready
module cordic_exp_scheduler
  import cordic_exp_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  cordic_exp_scheduler_if.slave  bus,
  output logic                   eng_init,
  output logic signed [XY_W-1:0] eng_x,
  output logic signed [XY_W-1:0] eng_y,
  output logic signed [Z_W-1:0]  eng_z,
  input  logic                   eng_done,
  input  logic signed [XY_W-1:0] eng_exp,
  output logic                   busy
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT+1);

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic                     done_q, done_cfm, tmo_hit, accept;
  logic [N_REQ-1:0]         grant;
  logic [ID_W-1:0]          grant_idx;
  logic [MAX_REQ*Z_W-1:0]   req_z_ext;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .en        (state == ST_IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    req_z_ext = '0;
    req_z_ext[N_REQ*Z_W-1:0] = bus.req_z;
  end

  assign accept        = |grant;
  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state == ST_HOLD);
  assign busy          = (state != ST_IDLE);
  assign eng_x         = X_INIT;
  assign eng_y         = X_INIT;

  // Two consecutive high samples ride out the engine's half-rate update.
  assign done_cfm = (state == ST_RUN) && eng_done && done_q;
  assign tmo_hit  = (state == ST_RUN) && (cnt == CNT_W'(TIMEOUT-1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_INIT;
      ST_INIT: if (cnt == CNT_W'(INIT_CYCLES-1)) state_nxt = ST_RUN;
      ST_RUN:  if (done_cfm || tmo_hit) state_nxt = ST_HOLD;
      ST_HOLD: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      done_q          <= 1'b0;
      eng_init        <= 1'b1;
      eng_z           <= '0;
      bus.rsp_id      <= '0;
      bus.rsp_exp     <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      eng_init <= (state_nxt != ST_RUN);
      done_q   <= (state == ST_RUN) && eng_done;
      if (state != state_nxt) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(TIMEOUT)) begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        eng_z      <= z_slice(req_z_ext, int'(grant_idx));
        bus.rsp_id <= grant_idx;
      end
      // A confirm in the same cycle as the timeout still counts as a clean finish.
      if (state == ST_RUN && state_nxt == ST_HOLD) begin
        bus.rsp_exp     <= eng_exp;
        bus.rsp_timeout <= ~done_cfm;
      end
    end
  end
endmodule

// File: tb/tb_cordic_exp_scheduler.sv
// Bench for cordic_exp_scheduler: behavioural requester/engine model with a
// round-robin and latency reference computed from plain arithmetic.
module tb_cordic_exp_scheduler;
  import cordic_exp_pkg::*;

  localparam int N        = 4;
  localparam int INIT_CYC = 2;
  localparam int TMO      = 63;
  localparam int NEVER    = 100000;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   eng_init, busy;
  logic                   eng_done = 1'b0;
  logic signed [XY_W-1:0] eng_x, eng_y;
  logic signed [XY_W-1:0] eng_exp = '0;
  logic signed [Z_W-1:0]  eng_z;

  cordic_exp_scheduler_if #(.N_REQ(N)) bus();

  cordic_exp_scheduler #(.N_REQ(N), .INIT_CYCLES(INIT_CYC), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .eng_init (eng_init),
    .eng_x    (eng_x),
    .eng_y    (eng_y),
    .eng_z    (eng_z),
    .eng_done (eng_done),
    .eng_exp  (eng_exp),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  bit             pend[N];
  logic [Z_W-1:0] pz[N];
  int             ptr_m = 0;
  int             ecnt = 0;
  int             e_d = NEVER;
  int             e_g = 0;
  bit             e_glitch = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Engine model: done rises e_d cycles after init falls, optional one-cycle glitch at e_g.
  task automatic step();
    @(negedge clk);
    if (eng_init) ecnt = 0;
    else          ecnt++;
    eng_done = !eng_init && ((ecnt >= e_d) || (e_glitch && ecnt == e_g));
  endtask

  task automatic drive_req();
    for (int k = 0; k < N; k++) begin
      bus.req_valid[k]           = pend[k];
      bus.req_z[k*Z_W +: Z_W]    = pz[k];
    end
  endtask

  function automatic int model_win();
    for (int i = 0; i < N; i++)
      if (pend[(ptr_m + i) % N]) return (ptr_m + i) % N;
    return -1;
  endfunction

  // Called at a negedge with the scheduler idle; returns at a negedge with it idle again.
  task automatic run_txn(input int d, input int g, input bit glitch, input logic [7:0] xv,
                         input int bp, input logic [N-1:0] add_mask);
    int win, lat_exp, waited;
    bit tmo_exp;
    drive_req();
    #1;
    win = model_win();
    check_eq("grant", {28'b0, bus.req_ready}, 32'(1) << win);
    e_d      = d;
    e_g      = g;
    e_glitch = glitch;
    eng_exp  = xv;
    tmo_exp  = (d + 1 > TMO);
    lat_exp  = INIT_CYC + 1 + ((d + 1 < TMO) ? d + 1 : TMO);
    step();
    check_eq("op_z", {25'b0, eng_z}, {25'b0, pz[win]});
    check_eq("op_id", {30'b0, bus.rsp_id}, win);
    check_eq("busy", {31'b0, busy}, 1);
    pend[win] = 1'b0;
    ptr_m     = (win + 1) % N;
    for (int k = 0; k < N; k++)
      if (add_mask[k] && !pend[k]) begin
        pend[k] = 1'b1;
        pz[k]   = Z_W'($urandom);
      end
    drive_req();
    waited = 1;
    while (!bus.rsp_valid && waited < TMO + 20) begin
      if (waited <= INIT_CYC + 1)
        check_eq("eng_init", {31'b0, eng_init}, (waited <= INIT_CYC) ? 1 : 0);
      check_eq("rdy_busy", {28'b0, bus.req_ready}, 0);
      step();
      waited++;
    end
    check_eq("latency", waited, lat_exp);
    check_eq("rsp_id", {30'b0, bus.rsp_id}, win);
    check_eq("rsp_exp", {24'b0, bus.rsp_exp}, {24'b0, xv});
    check_eq("rsp_tmo", {31'b0, bus.rsp_timeout}, {31'b0, tmo_exp});
    for (int i = 0; i < bp; i++) begin
      step();
      check_eq("bp_valid", {31'b0, bus.rsp_valid}, 1);
      check_eq("bp_id", {30'b0, bus.rsp_id}, win);
      check_eq("bp_exp", {24'b0, bus.rsp_exp}, {24'b0, xv});
      check_eq("bp_ready", {28'b0, bus.req_ready}, 0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check_eq("rsp_drop", {31'b0, bus.rsp_valid}, 0);
  endtask

  initial begin
    int nrsp;
    int r, d, g;
    bit gl, any;
    bus.req_valid = '0;
    bus.req_z     = '0;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b0;
      pz[k]   = '0;
    end

    repeat (3) step();
    check_eq("rst_valid", {31'b0, bus.rsp_valid}, 0);
    check_eq("rst_tmo", {31'b0, bus.rsp_timeout}, 0);
    check_eq("rst_id", {30'b0, bus.rsp_id}, 0);
    check_eq("rst_exp", {24'b0, bus.rsp_exp}, 0);
    check_eq("rst_z", {25'b0, eng_z}, 0);
    check_eq("rst_busy", {31'b0, busy}, 0);
    check_eq("rst_init", {31'b0, eng_init}, 1);
    check_eq("rst_x", {24'b0, eng_x}, 32);
    check_eq("rst_y", {24'b0, eng_y}, 32);
    rst = 1'b0;
    step();

    // All four requesting continuously: order 0,1,2,3,0.
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b1;
      pz[k]   = Z_W'($urandom);
    end
    repeat (5) run_txn(int'($urandom_range(1, 6)), 0, 1'b0, 8'($urandom), 0, '1);
    for (int k = 0; k < N; k++) pend[k] = 1'b0;

    // Single request, zero operand.
    pend[0] = 1'b1;
    pz[0]   = '0;
    run_txn(4, 0, 1'b0, 8'h20, 0, '0);

    // Backpressure with requester 2 queued behind the response.
    pend[1] = 1'b1;
    pz[1]   = Z_W'($urandom);
    run_txn(3, 0, 1'b0, 8'($urandom), 10, 4'b0100);
    run_txn(2, 0, 1'b0, 8'($urandom), 0, '0);

    // Timeout and the done/timeout tie on either side.
    pend[0] = 1'b1;
    pz[0]   = Z_W'($urandom);
    run_txn(NEVER, 0, 1'b0, 8'h7F, 0, '0);
    pend[1] = 1'b1;
    pz[1]   = Z_W'($urandom);
    run_txn(TMO - 1, 0, 1'b0, 8'($urandom), 0, '0);
    pend[2] = 1'b1;
    pz[2]   = Z_W'($urandom);
    run_txn(TMO, 0, 1'b0, 8'($urandom), 0, '0);

    // Single-cycle done glitch before the real completion.
    pend[3] = 1'b1;
    pz[3]   = Z_W'($urandom);
    run_txn(4, 2, 1'b1, 8'($urandom), 0, '0);

    repeat (40) begin
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1'b1;
          pz[k]   = Z_W'($urandom);
        end
        any |= pend[k];
      end
      if (!any) begin
        r       = int'($urandom_range(0, N - 1));
        pend[r] = 1'b1;
        pz[r]   = Z_W'($urandom);
      end
      r  = int'($urandom_range(0, 9));
      gl = (r == 0);
      g  = int'($urandom_range(1, 3));
      d  = gl ? g + 2 + int'($urandom_range(0, 3)) : int'($urandom_range(1, 8));
      run_txn(d, g, gl, 8'($urandom), int'($urandom_range(0, 3)), N'($urandom_range(0, 15)));
    end

    // Asynchronous reset three cycles into RUN.
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    pend[3]  = 1'b1;
    pz[3]    = Z_W'($urandom);
    e_d      = NEVER;
    e_glitch = 1'b0;
    drive_req();
    step();
    pend[3] = 1'b0;
    drive_req();
    repeat (4) step();
    check_eq("pre_rst_busy", {31'b0, busy}, 1);
    check_eq("pre_rst_init", {31'b0, eng_init}, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", {31'b0, busy}, 0);
    check_eq("arst_init", {31'b0, eng_init}, 1);
    check_eq("arst_valid", {31'b0, bus.rsp_valid}, 0);
    check_eq("arst_z", {25'b0, eng_z}, 0);
    check_eq("arst_id", {30'b0, bus.rsp_id}, 0);
    step();
    rst   = 1'b0;
    ptr_m = 0;
    nrsp  = 0;
    repeat (80) begin
      step();
      if (bus.rsp_valid) nrsp++;
    end
    check_eq("no_rsp", nrsp, 0);
    for (int k = 0; k < N; k++) pend[k] = 1'b1;
    drive_req();
    #1;
    check_eq("ptr_reset", {28'b0, bus.req_ready}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cordic_exp_scheduler.md
Name: cordic_exp_scheduler

Overview:
- Shares one 6-bit pipelined hyperbolic CORDIC exp engine between N_REQ requesters, e.g. neuron-group membrane-decay units.
- Arbitrates round-robin, loads the operand into the engine and sequences its init/run phases.
- Detects completion, with a timeout guard, and returns the result with the requester id over a valid/ready response channel.
- Sits between the neuron array and the exp engine. It is the only driver of the engine's init, x_i, y_i and z_i inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- Z_W, 7, signed angle/operand width (engine THETA_BITS+1).
- XY_W, 8, signed x/y/exp width (engine XY_BITS+1).
- X_INIT, 8'sd32, gain-compensated initial value driven on both eng_x and eng_y.
- INIT_CYCLES, 2, clk cycles eng_init is held with a new operand; minimum 2, because the engine's internal enable runs at clk/2.
- TIMEOUT, 63, RUN-state cycle limit before a forced capture.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  N_REQ  per-requester request.
- req_z  in  N_REQ*Z_W  packed signed operands; requester k occupies bits [k*Z_W +: Z_W].
- req_ready  out  N_REQ  one-hot grant; accept = req_valid[k] & req_ready[k].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  downstream accepts result.
- rsp_id  out  clog2(N_REQ)  index of the served requester.
- rsp_exp  out  XY_W  captured engine exp_o.
- rsp_timeout  out  1  result was force-captured at timeout.
- eng_init  out  1  to engine init.
- eng_x, eng_y  out  XY_W  to engine x_i and y_i.
- eng_z  out  Z_W  to engine z_i.
- eng_done  in  1  engine done.
- eng_exp  in  XY_W  engine exp_o.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - state = IDLE, rr pointer = 0.
  - rsp_valid, rsp_timeout, rsp_id, rsp_exp, eng_z, busy = 0.
  - eng_x = eng_y = X_INIT, eng_init = 1.
- States:
  - IDLE → INIT on accept.
  - INIT → RUN after INIT_CYCLES.
  - RUN → HOLD on done-confirm or timeout.
  - HOLD → IDLE on rsp_ready.
- eng_init is registered: 1 in every state except RUN. The engine is parked while idle, and its done output is cleared by init, so no stale done is possible on RUN entry.
- IDLE:
  - req_ready is combinational and one-hot.
  - The winner is the first asserted req_valid searching upward, with wrap, from the rr pointer.
  - On accept: register eng_z = req_z[winner] and rsp_id = winner; set pointer = winner+1 mod N_REQ; clear the cycle counter.
  - req_ready is 0 in all other states. No request is accepted while an operation or response is pending, even if rsp_ready and req_valid coincide in HOLD.
- INIT: hold the operand and count INIT_CYCLES cycles, then enter RUN.
- RUN:
  - The cycle counter increments every cycle.
  - Done-confirm is eng_done sampled high on 2 consecutive clk cycles; this covers the half-rate engine update.
  - On done-confirm: register rsp_exp = eng_exp and rsp_timeout = 0; enter HOLD.
  - If the counter reaches TIMEOUT first: capture eng_exp anyway, set rsp_timeout = 1, enter HOLD.
  - If done-confirm and timeout occur in the same cycle, done-confirm wins and rsp_timeout = 0.
- HOLD:
  - rsp_valid = 1.
  - rsp_exp, rsp_id and rsp_timeout stay stable until rsp_ready is sampled high.
  - On that edge, rsp_valid falls and the state returns to IDLE.
  - The next grant is possible in the following cycle.
- Latency, accept to rsp_valid: 1 + INIT_CYCLES + (engine run cycles + 1 confirm) cycles. Minimum is INIT_CYCLES+3.
- Operand z = 0 takes the normal path; the engine asserts done almost immediately.
- req_valid dropped by a non-winning requester has no effect. Requesters must hold req_valid and req_z until accepted.
- Asynchronous reset mid-operation aborts the in-flight operation. No response is produced and all outputs return to their reset values.
- Width rules:
  - eng_z is passed through sign-intact.
  - The counter is clog2(TIMEOUT+1) bits and saturates; it never wraps.

Decomposition:
- Package cordic_exp_pkg:
  - Z_W, XY_W, X_INIT constants.
  - State encoding IDLE/INIT/RUN/HOLD.
  - Packed-operand slice helper.
- One sub-module, rr_arbiter:
  - Parameterised by N_REQ.
  - Inputs: request vector, enable.
  - Outputs: one-hot grant, encoded index.
  - Pointer updates only on accept.
- The FSM, counter and capture registers live in cordic_exp_scheduler.

Test Plan:
- Single request: req_valid=4'b0001, req_z=7'sd0; engine model asserts done 4 cycles after init falls, exp=8'h20. Required: req_ready[0] pulses once; eng_init high for 2 cycles with eng_z=0; rsp_valid with rsp_id=0, rsp_exp=8'h20, rsp_timeout=0.
- Round-robin: all four requesters valid continuously, rsp_ready=1. Required: grant order 0,1,2,3,0, and no requester granted twice within 4 responses.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid with req_valid[2]=1 pending. Required: rsp_exp and rsp_id stable, req_ready=0 throughout; grant to requester 2 in the cycle after rsp_ready goes 1.
- Timeout: engine never asserts done, eng_exp=8'h7F. Required: rsp_valid after INIT_CYCLES+1+63 cycles, with rsp_timeout=1 and rsp_exp=8'h7F.
- Glitch rejection: eng_done high for a single cycle, then low, then high for 2 cycles. Required: capture only on the second pulse.
- Reset mid-RUN: assert rst asynchronously 3 cycles into RUN. Required: immediate IDLE, eng_init=1, rsp_valid=0, pointer=0, and no response emitted for the aborted request.
